// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM states, fixed SDRAM
// page numbers and the ASCII hex-digit decoder used for extension parsing.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE
    } state_t;

    // System ROM image pages (index 0), one per 16 KB block modulo 4
    localparam logic [8:0] PAGE_SYS0    = 9'h000;
    localparam logic [8:0] PAGE_SYS1    = 9'h100;
    localparam logic [8:0] PAGE_SYS2    = 9'h107;
    localparam logic [8:0] PAGE_SYS3    = 9'h1FF;
    // Expansion page used when the extension carries no hex digits
    localparam logic [8:0] PAGE_DEFAULT = 9'h1EE;

    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_Z    = 8'h5A;

    // Returns {valid, nibble} for an uppercase ASCII hex digit
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/ext_page_decode.sv
// Combinational decode of the two trailing extension characters into an
// expansion ROM page number and the combo-cartridge flag.
module ext_page_decode
    import rom_loader_pkg::*;
(
    input  logic [15:0] ext,
    output logic [8:0]  page,
    output logic        combo
);

    logic [4:0] hi_nib;
    logic [4:0] lo_nib;

    // "ZZ"/"Z0" are special; otherwise each hex digit overrides one nibble
    always_comb begin
        hi_nib = hex_decode(ext[15:8]);
        lo_nib = hex_decode(ext[7:0]);
        page   = PAGE_DEFAULT;
        combo  = 1'b0;
        if (ext == {CHAR_Z, CHAR_Z}) begin
            page = '0;
        end else if (ext == {CHAR_Z, CHAR_ZERO}) begin
            page  = '0;
            combo = 1'b1;
        end else begin
            if (hi_nib[4]) page[7:4] = hi_nib[3:0];
            if (lo_nib[4]) page[3:0] = lo_nib[3:0];
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams HPS download bytes into SDRAM, pacing each write on the SDRAM
// reference strobe, and keeps a 256-entry map of pages holding expansion ROMs.
module rom_loader
    import rom_loader_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic [15:0] ioctl_file_ext,
    output logic        ioctl_wait,
    output logic        boot_wr,
    output logic [22:0] boot_a,
    output logic [1:0]  boot_bank,
    output logic [7:0]  boot_dout,
    input  logic [7:0]  map_addr,
    output logic        rom_mapped
);

    state_t       state_q, state_d;
    logic         ioctl_wait_q, ioctl_wait_d;
    logic         boot_wr_q, boot_wr_d;
    logic [22:0]  boot_a_q, boot_a_d;
    logic [1:0]   boot_bank_q, boot_bank_d;
    logic [7:0]   boot_dout_q, boot_dout_d;
    logic [8:0]   page_q, page_d;
    logic         combo_q, combo_d;
    logic [255:0] map_q, map_d;
    logic         rom_mapped_q, rom_mapped_d;
    logic         dl_q, dl_d;

    logic [8:0]   ext_page;
    logic         ext_combo;

    logic [10:0]  blk;
    logic [8:0]   sys_page;
    logic         accept;
    logic [22:0]  wr_addr;
    logic [1:0]   wr_bank;
    logic         dual;

    ext_page_decode u_ext_page_decode (
        .ext   (ioctl_file_ext),
        .page  (ext_page),
        .combo (ext_combo)
    );

    // Target address/bank for the byte currently presented by the HPS
    always_comb begin
        blk      = ioctl_addr[24:14];
        sys_page = PAGE_SYS0;
        case (blk[1:0])
            2'd0:    sys_page = PAGE_SYS0;
            2'd1:    sys_page = PAGE_SYS1;
            2'd2:    sys_page = PAGE_SYS2;
            default: sys_page = PAGE_SYS3;
        endcase
        if (ioctl_index == 8'd0) begin
            accept  = (blk < 11'd8);
            wr_addr = {sys_page, ioctl_addr[13:0]};
            wr_bank = {1'b0, blk[2]};
        end else begin
            accept  = 1'b1;
            wr_addr = {page_q[8], page_q[7:0] + ioctl_addr[21:14], ioctl_addr[13:0]};
            wr_bank = {1'b0, &ioctl_index[7:6]};
        end
        dual = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
    end

    // Next-state logic: FSM, page tracking and ROM map updates
    always_comb begin
        state_d      = state_q;
        ioctl_wait_d = ioctl_wait_q;
        boot_wr_d    = boot_wr_q;
        boot_a_d     = boot_a_q;
        boot_bank_d  = boot_bank_q;
        boot_dout_d  = boot_dout_q;
        page_d       = page_q;
        combo_d      = combo_q;
        map_d        = map_q;
        dl_d         = ioctl_download;
        rom_mapped_d = map_q[map_addr];

        case (state_q)
            ST_IDLE: begin
                if (ioctl_wr && ioctl_download && accept) begin
                    boot_dout_d  = ioctl_dout;
                    boot_a_d     = wr_addr;
                    boot_bank_d  = wr_bank;
                    ioctl_wait_d = 1'b1;
                    state_d      = ST_ARM;
                end
            end
            ST_ARM: begin
                if (ce_ref) begin
                    boot_wr_d = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ce_ref) begin
                    boot_wr_d = 1'b0;
                    if (dual && boot_bank_q == 2'd0) begin
                        boot_bank_d = 2'd1;
                        state_d     = ST_ARM;
                    end else begin
                        ioctl_wait_d = 1'b0;
                        state_d      = ST_IDLE;
                        if (boot_a_q[22]) map_d[boot_a_q[21:14]] = 1'b1;
                        // Combo carts: first 16 KB at page 0, remainder moves to 0x1FF
                        if (combo_q && boot_a_q[13:0] == 14'h3FFF) begin
                            page_d  = PAGE_SYS3;
                            combo_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ioctl_download && !dl_q && ioctl_index != 8'd0) begin
            page_d  = ext_page;
            combo_d = ext_combo;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ioctl_wait_q <= 1'b0;
            boot_wr_q    <= 1'b0;
            boot_a_q     <= '0;
            boot_bank_q  <= '0;
            boot_dout_q  <= '0;
            page_q       <= PAGE_DEFAULT;
            combo_q      <= 1'b0;
            map_q        <= '0;
            rom_mapped_q <= 1'b0;
            dl_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ioctl_wait_q <= ioctl_wait_d;
            boot_wr_q    <= boot_wr_d;
            boot_a_q     <= boot_a_d;
            boot_bank_q  <= boot_bank_d;
            boot_dout_q  <= boot_dout_d;
            page_q       <= page_d;
            combo_q      <= combo_d;
            map_q        <= map_d;
            rom_mapped_q <= rom_mapped_d;
            dl_q         <= dl_d;
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign boot_wr    = boot_wr_q;
    assign boot_a     = boot_a_q;
    assign boot_bank  = boot_bank_q;
    assign boot_dout  = boot_dout_q;
    assign rom_mapped = rom_mapped_q;

endmodule
